// File: rtl/axi_sram_bridge2_if.sv
`default_nettype none
// ============================================================================
// Module      : axi_sram_bridge2_cpu_if / axi_sram_bridge2_axi_if
// Description : Signal bundles for axi_sram_bridge2.
//               axi_sram_bridge2_cpu_if - SRAM-like instruction and data
//                 request ports. master = CPU core, slave = bridge.
//               axi_sram_bridge2_axi_if - AXI3 AR/R/AW/W/B channels.
//                 master = bridge, slave = crossbar / memory.
// Parameters  : DATA_W - data width (32 or 64); STRB_W = DATA_W/8.
// Revision    : 1.0 - initial release
// ============================================================================

interface axi_sram_bridge2_cpu_if #(
    parameter int DATA_W = 32
);
    localparam int STRB_W = DATA_W / 8;

    // instruction port
    logic              inst_req;
    logic [31:0]       inst_addr;
    logic [3:0]        inst_len;
    logic              inst_addr_ok;
    logic              inst_rvalid;
    logic [DATA_W-1:0] inst_rdata;
    logic              inst_rlast;
    // data port
    logic              data_req;
    logic              data_wr;
    logic [31:0]       data_addr;
    logic [2:0]        data_size;
    logic [STRB_W-1:0] data_wstrb;
    logic [DATA_W-1:0] data_wdata;
    logic              data_addr_ok;
    logic              data_data_ok;
    logic [DATA_W-1:0] data_rdata;

    modport master (
        output inst_req, inst_addr, inst_len,
        input  inst_addr_ok, inst_rvalid, inst_rdata, inst_rlast,
        output data_req, data_wr, data_addr, data_size, data_wstrb, data_wdata,
        input  data_addr_ok, data_data_ok, data_rdata
    );

    modport slave (
        input  inst_req, inst_addr, inst_len,
        output inst_addr_ok, inst_rvalid, inst_rdata, inst_rlast,
        input  data_req, data_wr, data_addr, data_size, data_wstrb, data_wdata,
        output data_addr_ok, data_data_ok, data_rdata
    );
endinterface

interface axi_sram_bridge2_axi_if #(
    parameter int DATA_W = 32
);
    localparam int STRB_W = DATA_W / 8;

    // AR
    logic [3:0]        arid;
    logic [31:0]       araddr;
    logic [3:0]        arlen;
    logic [2:0]        arsize;
    logic [1:0]        arburst;
    logic [1:0]        arlock;
    logic [3:0]        arcache;
    logic [2:0]        arprot;
    logic              arvalid;
    logic              arready;
    // R
    logic [3:0]        rid;
    logic [DATA_W-1:0] rdata;
    logic [1:0]        rresp;
    logic              rlast;
    logic              rvalid;
    logic              rready;
    // AW
    logic [3:0]        awid;
    logic [31:0]       awaddr;
    logic [3:0]        awlen;
    logic [2:0]        awsize;
    logic [1:0]        awburst;
    logic [1:0]        awlock;
    logic [3:0]        awcache;
    logic [2:0]        awprot;
    logic              awvalid;
    logic              awready;
    // W
    logic [3:0]        wid;
    logic [DATA_W-1:0] wdata;
    logic [STRB_W-1:0] wstrb;
    logic              wlast;
    logic              wvalid;
    logic              wready;
    // B
    logic [3:0]        bid;
    logic [1:0]        bresp;
    logic              bvalid;
    logic              bready;

    modport master (
        output arid, araddr, arlen, arsize, arburst, arlock, arcache, arprot, arvalid,
        input  arready,
        input  rid, rdata, rresp, rlast, rvalid,
        output rready,
        output awid, awaddr, awlen, awsize, awburst, awlock, awcache, awprot, awvalid,
        input  awready,
        output wid, wdata, wstrb, wlast, wvalid,
        input  wready,
        input  bid, bresp, bvalid,
        output bready
    );

    modport slave (
        input  arid, araddr, arlen, arsize, arburst, arlock, arcache, arprot, arvalid,
        output arready,
        output rid, rdata, rresp, rlast, rvalid,
        input  rready,
        input  awid, awaddr, awlen, awsize, awburst, awlock, awcache, awprot, awvalid,
        output awready,
        input  wid, wdata, wstrb, wlast, wvalid,
        output wready,
        output bid, bresp, bvalid,
        input  bready
    );
endinterface

`default_nettype wire

// File: rtl/axi_sram_bridge2.sv
`default_nettype none
// ============================================================================
// Module      : axi_sram_bridge2
// Description : SRAM-like to AXI3 master bridge. An instruction read port
//               (burst capable) and a data read/write port (single beat) are
//               turned into AXI3 transactions. Reads and writes each run in
//               their own FSM, so one read and one write may be in flight at
//               once. A word-address hazard check keeps data reads and writes
//               to the same word in order.
// Ports       : aclk    - clock
//               aresetn - asynchronous active-low reset
//               cpu     - SRAM-like instruction/data ports (slave view)
//               axi     - AXI3 master channels AR/R/AW/W/B
// Parameters  : DATA_W  - 32 or 64
//               INST_ID - arid used for instruction reads
//               DATA_ID - arid/awid/wid used for data accesses
// Revision    : 1.0 - initial release
// ============================================================================

module axi_sram_bridge2 #(
    parameter int         DATA_W  = 32,
    parameter logic [3:0] INST_ID = 4'd0,
    parameter logic [3:0] DATA_ID = 4'd1
) (
    input  wire logic               aclk,
    input  wire logic               aresetn,
    axi_sram_bridge2_cpu_if.slave   cpu,
    axi_sram_bridge2_axi_if.master  axi
);

    localparam int         c_STRB_W    = DATA_W / 8;
    localparam logic [2:0] c_FULL_SIZE = 3'($clog2(c_STRB_W));

    typedef enum logic [1:0] {
        R_IDLE = 2'd0,
        R_AR   = 2'd1,
        R_R    = 2'd2
    } rd_state_t;

    typedef enum logic [2:0] {
        W_IDLE   = 3'd0,
        W_BOTH   = 3'd1,
        W_WONLY  = 3'd2,
        W_AWONLY = 3'd3,
        W_B      = 3'd4
    } wr_state_t;

    rd_state_t r_rstate, w_rstate_nxt;
    wr_state_t r_wstate, w_wstate_nxt;

    // read-side latches
    logic                r_rown_data;   // 1 = current read belongs to data port
    logic [3:0]          r_arid;
    logic [31:0]         r_araddr;
    logic [3:0]          r_arlen;
    logic [2:0]          r_arsize;

    // write-side latches
    logic [31:0]         r_awaddr;
    logic [2:0]          r_awsize;
    logic [c_STRB_W-1:0] r_wstrb;
    logic [DATA_W-1:0]   r_wdata;

    // ------------------------------------------------------------------------
    // Request acceptance and hazards
    // ------------------------------------------------------------------------
    logic w_data_rd_req;
    logic w_data_wr_req;
    logic w_rd_hazard;
    logic w_wr_hazard;
    logic w_data_rd_acc;
    logic w_data_wr_acc;
    logic w_inst_acc;
    logic w_rd_acc;

    assign w_data_rd_req = cpu.data_req & ~cpu.data_wr;
    assign w_data_wr_req = cpu.data_req &  cpu.data_wr;

    // A pending write to the same word must land before the read samples it.
    assign w_rd_hazard = (r_wstate != W_IDLE) &&
                         (r_awaddr[31:2] == cpu.data_addr[31:2]);

    // An outstanding data read of the same word must return old data first.
    assign w_wr_hazard = (r_rstate != R_IDLE) && r_rown_data &&
                         (r_araddr[31:2] == cpu.data_addr[31:2]);

    assign w_data_rd_acc = (r_rstate == R_IDLE) && w_data_rd_req && !w_rd_hazard;
    // Data reads win arbitration; a hazard-stalled data read does not block
    // instruction fetch.
    assign w_inst_acc    = (r_rstate == R_IDLE) && cpu.inst_req && !w_data_rd_acc;
    assign w_rd_acc      = w_data_rd_acc | w_inst_acc;
    assign w_data_wr_acc = (r_wstate == W_IDLE) && w_data_wr_req && !w_wr_hazard;

    assign cpu.inst_addr_ok = w_inst_acc;
    assign cpu.data_addr_ok = w_data_rd_acc | w_data_wr_acc;

    // ------------------------------------------------------------------------
    // Read FSM
    // ------------------------------------------------------------------------
    always_ff @(posedge aclk or negedge aresetn) begin
        if (!aresetn) begin
            r_rstate <= R_IDLE;
        end else begin
            r_rstate <= w_rstate_nxt;
        end
    end

    always_comb begin
        w_rstate_nxt = r_rstate;
        case (r_rstate)
            R_IDLE:  if (w_rd_acc)                    w_rstate_nxt = R_AR;
            R_AR:    if (axi.arready)                 w_rstate_nxt = R_R;
            R_R:     if (axi.rvalid && axi.rlast)     w_rstate_nxt = R_IDLE;
            default:                                  w_rstate_nxt = R_IDLE;
        endcase
    end

    always_ff @(posedge aclk or negedge aresetn) begin
        if (!aresetn) begin
            r_rown_data <= 1'b0;
            r_arid      <= 4'd0;
            r_araddr    <= 32'd0;
            r_arlen     <= 4'd0;
            r_arsize    <= 3'd0;
        end else if (w_rd_acc) begin
            r_rown_data <= w_data_rd_acc;
            if (w_data_rd_acc) begin
                r_arid   <= DATA_ID;
                r_araddr <= cpu.data_addr;
                r_arlen  <= 4'd0;
                r_arsize <= cpu.data_size;
            end else begin
                r_arid   <= INST_ID;
                r_araddr <= cpu.inst_addr;
                r_arlen  <= cpu.inst_len;
                r_arsize <= c_FULL_SIZE;
            end
        end
    end

    assign axi.arid    = r_arid;
    assign axi.araddr  = r_araddr;
    assign axi.arlen   = r_arlen;
    assign axi.arsize  = r_arsize;
    assign axi.arburst = 2'b01;
    assign axi.arlock  = 2'b00;
    assign axi.arcache = 4'b0000;
    assign axi.arprot  = 3'b000;
    assign axi.arvalid = (r_rstate == R_AR);
    assign axi.rready  = (r_rstate == R_R);

    // R beats are always consumed; only beats tagged with the owner's ID are
    // forwarded.
    logic w_rbeat;
    logic w_fwd_inst;
    logic w_fwd_data;

    assign w_rbeat    = axi.rready & axi.rvalid;
    assign w_fwd_inst = w_rbeat & ~r_rown_data & (axi.rid == INST_ID);
    assign w_fwd_data = w_rbeat &  r_rown_data & (axi.rid == DATA_ID);

    assign cpu.inst_rvalid = w_fwd_inst;
    assign cpu.inst_rdata  = w_fwd_inst ? axi.rdata : '0;
    assign cpu.inst_rlast  = w_fwd_inst & axi.rlast;
    assign cpu.data_rdata  = w_fwd_data ? axi.rdata : '0;

    // ------------------------------------------------------------------------
    // Write FSM
    // ------------------------------------------------------------------------
    logic w_b_done;

    always_ff @(posedge aclk or negedge aresetn) begin
        if (!aresetn) begin
            r_wstate <= W_IDLE;
        end else begin
            r_wstate <= w_wstate_nxt;
        end
    end

    always_comb begin
        w_wstate_nxt = r_wstate;
        case (r_wstate)
            W_IDLE:   if (w_data_wr_acc) w_wstate_nxt = W_BOTH;
            W_BOTH: begin
                if (axi.awready && axi.wready) w_wstate_nxt = W_B;
                else if (axi.awready)          w_wstate_nxt = W_WONLY;
                else if (axi.wready)           w_wstate_nxt = W_AWONLY;
            end
            W_WONLY:  if (axi.wready)  w_wstate_nxt = W_B;
            W_AWONLY: if (axi.awready) w_wstate_nxt = W_B;
            W_B:      if (w_b_done)    w_wstate_nxt = W_IDLE;
            default:                   w_wstate_nxt = W_IDLE;
        endcase
    end

    always_ff @(posedge aclk or negedge aresetn) begin
        if (!aresetn) begin
            r_awaddr <= 32'd0;
            r_awsize <= 3'd0;
            r_wstrb  <= '0;
            r_wdata  <= '0;
        end else if (w_data_wr_acc) begin
            r_awaddr <= cpu.data_addr;
            r_awsize <= cpu.data_size;
            r_wstrb  <= cpu.data_wstrb;
            r_wdata  <= cpu.data_wdata;
        end
    end

    logic w_wr_busy;
    assign w_wr_busy = (r_wstate != W_IDLE);

    assign axi.awid    = w_wr_busy ? DATA_ID : 4'd0;
    assign axi.awaddr  = r_awaddr;
    assign axi.awlen   = 4'd0;
    assign axi.awsize  = r_awsize;
    assign axi.awburst = 2'b01;
    assign axi.awlock  = 2'b00;
    assign axi.awcache = 4'b0000;
    assign axi.awprot  = 3'b000;
    assign axi.awvalid = (r_wstate == W_BOTH) || (r_wstate == W_AWONLY);

    assign axi.wid     = w_wr_busy ? DATA_ID : 4'd0;
    assign axi.wdata   = r_wdata;
    assign axi.wstrb   = r_wstrb;
    assign axi.wvalid  = (r_wstate == W_BOTH) || (r_wstate == W_WONLY);
    assign axi.wlast   = axi.wvalid;

    // data_data_ok is shared by read beats and write responses; a read beat
    // in the same cycle wins and the B response is stalled by holding bready
    // low.
    assign axi.bready       = (r_wstate == W_B) & ~w_fwd_data;
    assign w_b_done         = axi.bready & axi.bvalid;
    assign cpu.data_data_ok = w_fwd_data | w_b_done;

    // Response codes and bid carry no information this bridge acts on.
    logic w_unused_ok;
    assign w_unused_ok = ^{axi.rresp, axi.bresp, axi.bid};

endmodule

`default_nettype wire

// File: tb/tb_axi_sram_bridge2.sv
`default_nettype none
// ============================================================================
// Module      : tb_axi_sram_bridge2
// Description : Directed self-checking bench for axi_sram_bridge2. Drives the
//               CPU ports and plays the AXI slave by hand; expected values are
//               hand-computed constants.
// Revision    : 1.0 - initial release
// ============================================================================

module tb_axi_sram_bridge2;

    logic aclk;
    logic aresetn;
    int   n_checks;
    int   n_errors;

    axi_sram_bridge2_cpu_if #(.DATA_W(32)) cpu ();
    axi_sram_bridge2_axi_if #(.DATA_W(32)) axi ();

    axi_sram_bridge2 #(
        .DATA_W  (32),
        .INST_ID (4'd0),
        .DATA_ID (4'd1)
    ) u_dut (
        .aclk    (aclk),
        .aresetn (aresetn),
        .cpu     (cpu),
        .axi     (axi)
    );

    initial aclk = 1'b0;
    always #5 aclk = ~aclk;

    task automatic check_val(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        n_checks++;
        if (obs !== exp) begin
            n_errors++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h", tag, obs, exp);
        end
    endtask

    task automatic clear_inputs();
        cpu.inst_req   = 1'b0;
        cpu.inst_addr  = 32'd0;
        cpu.inst_len   = 4'd0;
        cpu.data_req   = 1'b0;
        cpu.data_wr    = 1'b0;
        cpu.data_addr  = 32'd0;
        cpu.data_size  = 3'd0;
        cpu.data_wstrb = 4'd0;
        cpu.data_wdata = 32'd0;
        axi.arready    = 1'b0;
        axi.rid        = 4'd0;
        axi.rdata      = 32'd0;
        axi.rresp      = 2'd0;
        axi.rlast      = 1'b0;
        axi.rvalid     = 1'b0;
        axi.awready    = 1'b0;
        axi.wready     = 1'b0;
        axi.bid        = 4'd0;
        axi.bresp      = 2'd0;
        axi.bvalid     = 1'b0;
    endtask

    task automatic set_rbeat(input logic v, input logic [3:0] id,
                             input logic [31:0] d, input logic last);
        axi.rvalid = v;
        axi.rid    = id;
        axi.rdata  = d;
        axi.rlast  = last;
    endtask

    initial begin
        n_checks = 0;
        n_errors = 0;
        aresetn  = 1'b0;
        clear_inputs();

        // ---------------- reset state ----------------
        repeat (3) @(negedge aclk);
        #1;
        check_val("rst_arvalid",  axi.arvalid, 1'b0);
        check_val("rst_rready",   axi.rready, 1'b0);
        check_val("rst_awvalid",  axi.awvalid, 1'b0);
        check_val("rst_wvalid",   axi.wvalid, 1'b0);
        check_val("rst_bready",   axi.bready, 1'b0);
        check_val("rst_data_ok",  cpu.data_data_ok, 1'b0);
        check_val("rst_inst_rv",  cpu.inst_rvalid, 1'b0);
        check_val("rst_araddr",   axi.araddr, 32'd0);
        check_val("rst_awid",     axi.awid, 4'd0);
        aresetn = 1'b1;
        @(negedge aclk);

        // ---------------- single inst read, arready delayed ----------------
        cpu.inst_req  = 1'b1;
        cpu.inst_addr = 32'hBFC0_0000;
        cpu.inst_len  = 4'd0;
        #1 check_val("t1_addr_ok", cpu.inst_addr_ok, 1'b1);
        @(negedge aclk);
        cpu.inst_req = 1'b0;
        #1;
        check_val("t1_arvalid", axi.arvalid, 1'b1);
        check_val("t1_araddr",  axi.araddr, 32'hBFC0_0000);
        check_val("t1_arlen",   axi.arlen, 4'd0);
        check_val("t1_arsize",  axi.arsize, 3'd2);
        check_val("t1_arid",    axi.arid, 4'd0);
        check_val("t1_arburst", axi.arburst, 2'b01);
        @(negedge aclk);
        #1;
        check_val("t1_ar_hold",  axi.arvalid, 1'b1);
        check_val("t1_addr_hold", axi.araddr, 32'hBFC0_0000);
        @(negedge aclk);
        axi.arready = 1'b1;
        #1 check_val("t1_ar_hs", axi.arvalid, 1'b1);
        @(negedge aclk);
        axi.arready = 1'b0;
        #1;
        check_val("t1_ar_done", axi.arvalid, 1'b0);
        check_val("t1_rready",  axi.rready, 1'b1);
        set_rbeat(1'b1, 4'd0, 32'h3C08_BFAF, 1'b1);
        #1;
        check_val("t1_inst_rv",    cpu.inst_rvalid, 1'b1);
        check_val("t1_inst_rdata", cpu.inst_rdata, 32'h3C08_BFAF);
        check_val("t1_inst_rlast", cpu.inst_rlast, 1'b1);
        @(negedge aclk);
        set_rbeat(1'b0, 4'd0, 32'd0, 1'b0);
        #1 check_val("t1_rready_off", axi.rready, 1'b0);

        // ---------------- inst burst refill ----------------
        cpu.inst_req  = 1'b1;
        cpu.inst_addr = 32'h0000_1000;
        cpu.inst_len  = 4'd3;
        @(negedge aclk);
        cpu.inst_req = 1'b0;
        axi.arready  = 1'b1;
        #1;
        check_val("t2_arlen",  axi.arlen, 4'd3);
        check_val("t2_arsize", axi.arsize, 3'd2);
        @(negedge aclk);
        axi.arready = 1'b0;
        for (int i = 0; i < 4; i++) begin
            set_rbeat(1'b1, 4'd0, 32'h11 * (i + 1), (i == 3));
            #1;
            check_val($sformatf("t2_rv%0d", i),    cpu.inst_rvalid, 1'b1);
            check_val($sformatf("t2_rdata%0d", i), cpu.inst_rdata, 32'h11 * (i + 1));
            check_val($sformatf("t2_rlast%0d", i), cpu.inst_rlast, (i == 3));
            @(negedge aclk);
            if (i == 0) begin
                // stray beat with a foreign ID: consumed, not forwarded
                set_rbeat(1'b1, 4'd1, 32'hFFFF_FFFF, 1'b0);
                #1 check_val("t2_foreign_rv", cpu.inst_rvalid, 1'b0);
                @(negedge aclk);
            end
        end
        set_rbeat(1'b0, 4'd0, 32'd0, 1'b0);
        #1 check_val("t2_idle", axi.rready, 1'b0);

        // ---------------- data write, wready before awready ----------------
        cpu.data_req   = 1'b1;
        cpu.data_wr    = 1'b1;
        cpu.data_addr  = 32'h8000_1004;
        cpu.data_size  = 3'd2;
        cpu.data_wstrb = 4'b0011;
        cpu.data_wdata = 32'hDEAD_BEEF;
        #1 check_val("t3_addr_ok", cpu.data_addr_ok, 1'b1);
        @(negedge aclk);
        cpu.data_req = 1'b0;
        #1;
        check_val("t3_both_aw", axi.awvalid, 1'b1);
        check_val("t3_both_w",  axi.wvalid, 1'b1);
        check_val("t3_awaddr",  axi.awaddr, 32'h8000_1004);
        check_val("t3_awsize",  axi.awsize, 3'd2);
        check_val("t3_awlen",   axi.awlen, 4'd0);
        check_val("t3_wstrb",   axi.wstrb, 4'b0011);
        check_val("t3_wdata",   axi.wdata, 32'hDEAD_BEEF);
        check_val("t3_wlast",   axi.wlast, 1'b1);
        check_val("t3_awid",    axi.awid, 4'd1);
        check_val("t3_wid",     axi.wid, 4'd1);
        axi.wready = 1'b1;
        @(negedge aclk);
        axi.wready = 1'b0;
        #1;
        check_val("t3_awonly_aw", axi.awvalid, 1'b1);
        check_val("t3_awonly_w",  axi.wvalid, 1'b0);
        axi.awready = 1'b1;
        @(negedge aclk);
        axi.awready = 1'b0;
        #1;
        check_val("t3_b_aw",     axi.awvalid, 1'b0);
        check_val("t3_b_bready", axi.bready, 1'b1);
        check_val("t3_b_nook",   cpu.data_data_ok, 1'b0);
        axi.bvalid = 1'b1;
        #1 check_val("t3_b_ok", cpu.data_data_ok, 1'b1);
        @(negedge aclk);
        axi.bvalid = 1'b0;
        #1;
        check_val("t3_post_ok",     cpu.data_data_ok, 1'b0);
        check_val("t3_post_bready", axi.bready, 1'b0);

        // ---------------- arbitration ----------------
        cpu.inst_req  = 1'b1;
        cpu.inst_addr = 32'h0000_2000;
        cpu.inst_len  = 4'd0;
        cpu.data_req  = 1'b1;
        cpu.data_wr   = 1'b0;
        cpu.data_addr = 32'h8000_0100;
        cpu.data_size = 3'd2;
        #1;
        check_val("t4_data_ok", cpu.data_addr_ok, 1'b1);
        check_val("t4_inst_no", cpu.inst_addr_ok, 1'b0);
        @(negedge aclk);
        cpu.data_req = 1'b0;
        axi.arready  = 1'b1;
        #1;
        check_val("t4_arid",    axi.arid, 4'd1);
        check_val("t4_araddr",  axi.araddr, 32'h8000_0100);
        check_val("t4_inst_ar", cpu.inst_addr_ok, 1'b0);
        @(negedge aclk);
        axi.arready = 1'b0;
        set_rbeat(1'b1, 4'd1, 32'hCAFE_F00D, 1'b1);
        #1;
        check_val("t4_dok",     cpu.data_data_ok, 1'b1);
        check_val("t4_drdata",  cpu.data_rdata, 32'hCAFE_F00D);
        check_val("t4_no_irv",  cpu.inst_rvalid, 1'b0);
        check_val("t4_inst_rr", cpu.inst_addr_ok, 1'b0);
        @(negedge aclk);
        set_rbeat(1'b0, 4'd0, 32'd0, 1'b0);
        #1 check_val("t4_inst_ok", cpu.inst_addr_ok, 1'b1);
        @(negedge aclk);
        cpu.inst_req = 1'b0;
        axi.arready  = 1'b1;
        #1;
        check_val("t4_i_arid",   axi.arid, 4'd0);
        check_val("t4_i_araddr", axi.araddr, 32'h0000_2000);
        @(negedge aclk);
        axi.arready = 1'b0;
        set_rbeat(1'b1, 4'd0, 32'h0000_0777, 1'b1);
        #1 check_val("t4_i_rdata", cpu.inst_rdata, 32'h0000_0777);
        @(negedge aclk);
        set_rbeat(1'b0, 4'd0, 32'd0, 1'b0);

        // ---------------- hazards and data-port collision ----------------
        cpu.data_req   = 1'b1;
        cpu.data_wr    = 1'b1;
        cpu.data_addr  = 32'h8000_0010;
        cpu.data_wstrb = 4'hF;
        cpu.data_wdata = 32'h1234_5678;
        #1 check_val("t5_wr_ok", cpu.data_addr_ok, 1'b1);
        @(negedge aclk);
        cpu.data_req = 1'b0;
        axi.awready  = 1'b1;
        axi.wready   = 1'b1;
        @(negedge aclk);                 // now in W_B
        axi.awready   = 1'b0;
        axi.wready    = 1'b0;
        cpu.data_req  = 1'b1;
        cpu.data_wr   = 1'b0;
        cpu.data_addr = 32'h8000_0012;
        #1 check_val("t5_hz_block0", cpu.data_addr_ok, 1'b0);
        @(negedge aclk);
        #1 check_val("t5_hz_block1", cpu.data_addr_ok, 1'b0);
        axi.bvalid = 1'b1;
        #1;
        check_val("t5_b_ok",      cpu.data_data_ok, 1'b1);
        check_val("t5_hz_block2", cpu.data_addr_ok, 1'b0);
        @(negedge aclk);
        axi.bvalid = 1'b0;
        #1 check_val("t5_hz_release", cpu.data_addr_ok, 1'b1);
        @(negedge aclk);
        cpu.data_req = 1'b0;
        axi.arready  = 1'b1;
        #1 check_val("t5_rd_araddr", axi.araddr, 32'h8000_0012);
        @(negedge aclk);
        axi.arready = 1'b0;
        // write to the word of the outstanding data read must wait
        cpu.data_req   = 1'b1;
        cpu.data_wr    = 1'b1;
        cpu.data_addr  = 32'h8000_0010;
        #1 check_val("t5_wr_hazard", cpu.data_addr_ok, 1'b0);
        set_rbeat(1'b1, 4'd1, 32'hAA55_AA55, 1'b1);
        #1 check_val("t5_rd_data", cpu.data_rdata, 32'hAA55_AA55);
        @(negedge aclk);
        set_rbeat(1'b0, 4'd0, 32'd0, 1'b0);
        #1 check_val("t5_wr_release", cpu.data_addr_ok, 1'b1);
        @(negedge aclk);
        cpu.data_req = 1'b0;
        axi.awready  = 1'b1;
        axi.wready   = 1'b1;
        @(negedge aclk);                 // in W_B again
        axi.awready   = 1'b0;
        axi.wready    = 1'b0;
        cpu.data_req  = 1'b1;
        cpu.data_wr   = 1'b0;
        cpu.data_addr = 32'h8000_0020;
        #1 check_val("t5_other_word", cpu.data_addr_ok, 1'b1);
        @(negedge aclk);
        cpu.data_req = 1'b0;
        axi.arready  = 1'b1;
        @(negedge aclk);
        axi.arready = 1'b0;
        set_rbeat(1'b1, 4'd1, 32'h0BAD_F00D, 1'b1);
        axi.bvalid = 1'b1;
        #1;
        check_val("t5_col_ok",     cpu.data_data_ok, 1'b1);
        check_val("t5_col_rdata",  cpu.data_rdata, 32'h0BAD_F00D);
        check_val("t5_col_bready", axi.bready, 1'b0);
        @(negedge aclk);
        set_rbeat(1'b0, 4'd0, 32'd0, 1'b0);
        #1;
        check_val("t5_col_b_bready", axi.bready, 1'b1);
        check_val("t5_col_b_ok",     cpu.data_data_ok, 1'b1);
        check_val("t5_col_b_rdata",  cpu.data_rdata, 32'd0);
        @(negedge aclk);
        axi.bvalid = 1'b0;
        #1 check_val("t5_col_idle", axi.bready, 1'b0);

        // ---------------- reset mid-burst ----------------
        cpu.inst_req  = 1'b1;
        cpu.inst_addr = 32'h0000_3000;
        cpu.inst_len  = 4'd3;
        @(negedge aclk);
        cpu.inst_req = 1'b0;
        axi.arready  = 1'b1;
        @(negedge aclk);
        axi.arready = 1'b0;
        set_rbeat(1'b1, 4'd0, 32'h0000_0001, 1'b0);
        @(negedge aclk);
        set_rbeat(1'b1, 4'd0, 32'h0000_0002, 1'b0);
        #1 check_val("t6_beat2", cpu.inst_rvalid, 1'b1);
        #1 aresetn = 1'b0;
        #1;
        check_val("t6_rst_rv",    cpu.inst_rvalid, 1'b0);
        check_val("t6_rst_rdata", cpu.inst_rdata, 32'd0);
        check_val("t6_rst_rready", axi.rready, 1'b0);
        check_val("t6_rst_arvalid", axi.arvalid, 1'b0);
        @(negedge aclk);
        set_rbeat(1'b0, 4'd0, 32'd0, 1'b0);
        aresetn = 1'b1;
        @(negedge aclk);
        cpu.inst_req  = 1'b1;
        cpu.inst_addr = 32'h0000_4000;
        cpu.inst_len  = 4'd0;
        #1 check_val("t6_new_ok", cpu.inst_addr_ok, 1'b1);
        @(negedge aclk);
        cpu.inst_req = 1'b0;
        axi.arready  = 1'b1;
        #1;
        check_val("t6_new_araddr", axi.araddr, 32'h0000_4000);
        check_val("t6_new_arlen",  axi.arlen, 4'd0);
        @(negedge aclk);
        axi.arready = 1'b0;
        set_rbeat(1'b1, 4'd0, 32'h5A5A_5A5A, 1'b1);
        #1;
        check_val("t6_new_rdata", cpu.inst_rdata, 32'h5A5A_5A5A);
        check_val("t6_new_rlast", cpu.inst_rlast, 1'b1);
        @(negedge aclk);
        set_rbeat(1'b0, 4'd0, 32'd0, 1'b0);
        #1 check_val("t6_done", axi.rready, 1'b0);

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule

`default_nettype wire
